// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP add/multiply control unit.
//   - state_t        : control FSM states (also exported on the debug port)
//   - DEF_*          : default values for the control unit parameters
//   - OP_*           : operation encodings captured from op_mul
//   - *_W            : field widths used throughout the control slice
package fp_ctrl_pkg;

  localparam int DEF_NORM_POS   = 25;
  localparam int DEF_MAX_ALIGN  = 26;
  localparam int DEF_MAX_RENORM = 1;

  localparam int SH_W     = 5;
  localparam int EXP_W    = 8;
  localparam int RENORM_W = 2;

  localparam logic OP_ADDSUB = 1'b0;
  localparam logic OP_MUL    = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_EXP    = 4'd1,
    S_ALIGN  = 4'd2,
    S_SETTLE = 4'd3,
    S_SCAN   = 4'd4,
    S_LOADE  = 4'd5,
    S_NORM   = 4'd6,
    S_CHK    = 4'd7,
    S_RENORM = 4'd8,
    S_DONE   = 4'd9
  } state_t;

endpackage

// File: rtl/fp_lead_one_scan.sv
// Leading-one finder over the big-ULA mantissa.
// Build option FP_CTRL_PRIO_ENC_EN:
//   defined   - single-cycle combinational priority encoder
//   undefined - serial scan from bit NORM_POS downwards, one bit per cycle
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   init       load the scan counter with NORM_POS (cycle before scanning)
//   en         scan is active this cycle
//   vec        mantissa being scanned
//   sh         NORM_POS - position of the leading one (valid with found)
//   found      leading one located this cycle
//   scan_done  scan finished this cycle (found, or bit 0 reached with no one)
module fp_lead_one_scan
  import fp_ctrl_pkg::*;
#(
  parameter int NORM_POS = DEF_NORM_POS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  input  logic [NORM_POS:0] vec,
  output logic [SH_W-1:0]   sh,
  output logic              found,
  output logic              scan_done
);

`ifdef FP_CTRL_PRIO_ENC_EN

  logic [SH_W-1:0] pos;
  logic            hit;

  // Ascending loop: the last (highest) set bit wins.
  always_comb begin
    pos = '0;
    hit = 1'b0;
    for (int i = 0; i <= NORM_POS; i++) begin
      if (vec[i]) begin
        pos = SH_W'(i);
        hit = 1'b1;
      end
    end
  end

  assign found     = en & hit;
  assign scan_done = en;
  assign sh        = SH_W'(NORM_POS) - pos;

  // Clock, reset and init are only needed by the serial build.
  wire unused_ok = &{1'b0, clk, rst, init};

`else

  logic [SH_W-1:0] cnt_q;
  logic            bit_hit;

  assign bit_hit   = vec[cnt_q];
  assign found     = en & bit_hit;
  assign scan_done = en & (bit_hit | (cnt_q == '0));
  assign sh        = SH_W'(NORM_POS) - cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (init) begin
      cnt_q <= SH_W'(NORM_POS);
    end else if (en && !scan_done) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`endif

endmodule

// File: rtl/fp_control_unit.sv
// Control FSM sequencing the FP add/multiply datapath.
// Accepts start in IDLE, drives every datapath select / subtract / shift
// control, reads back exp_diff, big_ula_out and overflow, and pulses done.
// Optional build macro: FP_CTRL_PRIO_ENC_EN (single-cycle leading-one scan).
// Ports:
//   clk, reset                       clock / asynchronous active-high reset
//   start, op_mul, op_sub            request and operation (captured on accept)
//   exp_diff                         registered small-ULA result
//   big_ula_out                      big-ULA mantissa result
//   overflow                         rounding-stage mantissa overflow
//   tamanho / tamanho2 / tamanho3    align shift / normalise shift / exp adjust
//   soma_multiplica_small_ula/big_ula, subtrador_big_ula     ULA controls
//   decisor_mux_expoente_escolhido, decisor_mux_saida_big_ula,
//   decisor_shift_right_left, subtrador_Somador_subtrador    mux/shift controls
//   load                             one-cycle strobe to the rounding register
//   busy, done, zero                 status (zero valid with done)
//   state_dbg                        current FSM state
// Handshake: start is taken only in IDLE; busy is high from the cycle after
// accept until the cycle done pulses; start while busy is ignored.
// All outputs are registered: the comb block computes the value each output
// must carry in the next state and the flops present it.
module fp_control_unit
  import fp_ctrl_pkg::*;
#(
  parameter int NORM_POS   = DEF_NORM_POS,
  parameter int MAX_ALIGN  = DEF_MAX_ALIGN,
  parameter int MAX_RENORM = DEF_MAX_RENORM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op_mul,
  input  logic              op_sub,
  input  logic [EXP_W-1:0]  exp_diff,
  input  logic [NORM_POS:0] big_ula_out,
  input  logic              overflow,
  output logic [SH_W-1:0]   tamanho,
  output logic [SH_W-1:0]   tamanho2,
  output logic [EXP_W-1:0]  tamanho3,
  output logic              soma_multiplica_small_ula,
  output logic              soma_multiplica_big_ula,
  output logic              subtrador_big_ula,
  output logic              decisor_mux_expoente_escolhido,
  output logic              decisor_mux_saida_big_ula,
  output logic              decisor_shift_right_left,
  output logic              subtrador_Somador_subtrador,
  output logic              load,
  output logic              busy,
  output logic              done,
  output logic              zero,
  output state_t            state_dbg
);

  state_t              state_q, state_d;
  logic                op_mul_q, op_mul_d;
  logic                op_sub_q, op_sub_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic [RENORM_W-1:0] renorm_q, renorm_d;

  logic [SH_W-1:0]     tamanho_d, tamanho2_d;
  logic [EXP_W-1:0]    tamanho3_d;
  logic                soma_small_d, soma_big_d, sub_big_d;
  logic                mux_exp_d, mux_saida_d, shift_left_d, sub_ss_d;
  logic                load_d, busy_d, done_d, zero_d;

  logic                scan_init;
  logic [SH_W-1:0]     scan_sh;
  logic                scan_found;
  logic                scan_done;
  logic [SH_W-1:0]     align_sat;

  assign state_dbg = state_q;

  // Saturating alignment amount: beyond MAX_ALIGN everything shifts out anyway.
  assign align_sat = (exp_diff > EXP_W'(MAX_ALIGN)) ? SH_W'(MAX_ALIGN)
                                                    : exp_diff[SH_W-1:0];

  fp_lead_one_scan #(
    .NORM_POS (NORM_POS)
  ) u_scan (
    .clk       (clk),
    .rst       (reset),
    .init      (scan_init),
    .en        (state_q == S_SCAN),
    .vec       (big_ula_out),
    .sh        (scan_sh),
    .found     (scan_found),
    .scan_done (scan_done)
  );

  always_comb begin
    state_d      = state_q;
    op_mul_d     = op_mul_q;
    op_sub_d     = op_sub_q;
    sh_d         = sh_q;
    renorm_d     = renorm_q;
    scan_init    = 1'b0;
    // Operation-wide controls hold their value for the whole operation.
    tamanho_d    = tamanho;
    soma_small_d = soma_multiplica_small_ula;
    soma_big_d   = soma_multiplica_big_ula;
    sub_big_d    = subtrador_big_ula;
    // Per-step controls are only meaningful alongside a load strobe.
    tamanho2_d   = '0;
    tamanho3_d   = '0;
    mux_exp_d    = 1'b0;
    mux_saida_d  = 1'b0;
    shift_left_d = 1'b0;
    sub_ss_d     = 1'b0;
    load_d       = 1'b0;
    done_d       = 1'b0;
    zero_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_EXP;
          op_mul_d     = op_mul;
          op_sub_d     = op_sub;
          soma_small_d = ~op_mul;
          soma_big_d   = ~op_mul;
          tamanho_d    = '0;
          sub_big_d    = 1'b0;
          sh_d         = '0;
          renorm_d     = '0;
        end
      end
      S_EXP: begin
        state_d   = S_ALIGN;
        tamanho_d = (op_mul_q == OP_MUL) ? '0 : align_sat;
        sub_big_d = op_sub_q & (op_mul_q == OP_ADDSUB);
      end
      S_ALIGN: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d   = S_SCAN;
        scan_init = 1'b1;
      end
      S_SCAN: begin
        if (scan_done) begin
          if (scan_found) begin
            state_d    = S_LOADE;
            sh_d       = scan_sh;
            load_d     = 1'b1;
            tamanho3_d = (op_mul_q == OP_MUL) ? '0 : exp_diff;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            zero_d  = 1'b1;
          end
        end
      end
      S_LOADE: begin
        state_d      = S_NORM;
        mux_exp_d    = 1'b1;
        sub_ss_d     = 1'b1;
        tamanho2_d   = sh_q;
        tamanho3_d   = {{(EXP_W-SH_W){1'b0}}, sh_q};
        shift_left_d = 1'b1;
        load_d       = 1'b1;
      end
      S_NORM: begin
        state_d = S_CHK;
      end
      S_CHK: begin
        if (overflow && (renorm_q < RENORM_W'(MAX_RENORM))) begin
          state_d     = S_RENORM;
          mux_saida_d = 1'b1;
          tamanho2_d  = SH_W'(1);
          tamanho3_d  = EXP_W'(1);
          load_d      = 1'b1;
          renorm_d    = renorm_q + 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_RENORM: begin
        state_d = S_CHK;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                        <= S_IDLE;
      op_mul_q                       <= 1'b0;
      op_sub_q                       <= 1'b0;
      sh_q                           <= '0;
      renorm_q                       <= '0;
      tamanho                        <= '0;
      tamanho2                       <= '0;
      tamanho3                       <= '0;
      soma_multiplica_small_ula      <= 1'b0;
      soma_multiplica_big_ula        <= 1'b0;
      subtrador_big_ula              <= 1'b0;
      decisor_mux_expoente_escolhido <= 1'b0;
      decisor_mux_saida_big_ula      <= 1'b0;
      decisor_shift_right_left       <= 1'b0;
      subtrador_Somador_subtrador    <= 1'b0;
      load                           <= 1'b0;
      busy                           <= 1'b0;
      done                           <= 1'b0;
      zero                           <= 1'b0;
    end else begin
      state_q                        <= state_d;
      op_mul_q                       <= op_mul_d;
      op_sub_q                       <= op_sub_d;
      sh_q                           <= sh_d;
      renorm_q                       <= renorm_d;
      tamanho                        <= tamanho_d;
      tamanho2                       <= tamanho2_d;
      tamanho3                       <= tamanho3_d;
      soma_multiplica_small_ula      <= soma_small_d;
      soma_multiplica_big_ula        <= soma_big_d;
      subtrador_big_ula              <= sub_big_d;
      decisor_mux_expoente_escolhido <= mux_exp_d;
      decisor_mux_saida_big_ula      <= mux_saida_d;
      decisor_shift_right_left       <= shift_left_d;
      subtrador_Somador_subtrador    <= sub_ss_d;
      load                           <= load_d;
      busy                           <= busy_d;
      done                           <= done_d;
      zero                           <= zero_d;
    end
  end

endmodule

// File: tb/tb_fp_control_unit.sv
module tb_fp_control_unit;
  import fp_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start, op_mul, op_sub, overflow;
  logic [7:0]  exp_diff;
  logic [25:0] big_ula_out;
  logic [4:0]  tamanho, tamanho2;
  logic [7:0]  tamanho3;
  logic        soma_s, soma_b, sub_big, mux_exp, mux_saida, shift_lr, sub_ss;
  logic        load, busy, done, zero;
  state_t      state_dbg;

  always #5 clk = ~clk;

  fp_control_unit dut (
    .clk                            (clk),
    .reset                          (reset),
    .start                          (start),
    .op_mul                         (op_mul),
    .op_sub                         (op_sub),
    .exp_diff                       (exp_diff),
    .big_ula_out                    (big_ula_out),
    .overflow                       (overflow),
    .tamanho                        (tamanho),
    .tamanho2                       (tamanho2),
    .tamanho3                       (tamanho3),
    .soma_multiplica_small_ula      (soma_s),
    .soma_multiplica_big_ula        (soma_b),
    .subtrador_big_ula              (sub_big),
    .decisor_mux_expoente_escolhido (mux_exp),
    .decisor_mux_saida_big_ula      (mux_saida),
    .decisor_shift_right_left       (shift_lr),
    .subtrador_Somador_subtrador    (sub_ss),
    .load                           (load),
    .busy                           (busy),
    .done                           (done),
    .zero                           (zero),
    .state_dbg                      (state_dbg)
  );

  logic [28:0] all_outs;
  assign all_outs = {tamanho, tamanho2, tamanho3, soma_s, soma_b, sub_big, mux_exp,
                     mux_saida, shift_lr, sub_ss, load, busy, done, zero};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected accept-to-done latency from the mantissa and overflow setting.
  function automatic int exp_lat(input logic [25:0] big, input logic ovf);
    int pos;
    int lat;
    pos = -1;
    for (int i = 0; i < 26; i++) if (big[i]) pos = i;
`ifdef FP_CTRL_PRIO_ENC_EN
    if (pos < 0) return 4;
    lat = 7;
`else
    if (pos < 0) return 3 + 26;
    lat = 6 + (25 - pos + 1);
`endif
    if (ovf) lat += 2;
    return lat;
  endfunction

  // Observations of one operation.
  int          r_cycles, r_loads, r_norms, r_renorms;
  logic [4:0]  r_tam, n_t2, rn_t2;
  logic [7:0]  n_t3, e_t3, rn_t3;
  logic        n_sub, n_mux, e_sub, e_mux, rn_sub;
  logic        r_soma_s, r_soma_b, r_sub_big, r_zero, r_busy;

  // ---------------- driver ----------------
  task automatic run_op(input logic m, input logic s, input logic [7:0] ed,
                        input logic [25:0] big, input logic ovf, input bit poke);
    @(negedge clk);
    op_mul = m; op_sub = s; exp_diff = ed; big_ula_out = big; overflow = ovf; start = 1'b1;
    r_cycles = 0; r_loads = 0; r_norms = 0; r_renorms = 0;
    n_t2 = '1; n_t3 = '1; e_t3 = '1; rn_t2 = '1; rn_t3 = '1;
    n_sub = 1'bx; n_mux = 1'bx; e_sub = 1'bx; e_mux = 1'bx; rn_sub = 1'bx;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_on_accept", 32'(busy), 1);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (poke && c == 2) begin start = 1'b1; op_mul = ~m; end
      if (poke && c == 4) begin start = 1'b0; op_mul = m; end
      if (load) begin
        r_loads++;
        if (shift_lr) begin
          r_norms++; n_t2 = tamanho2; n_t3 = tamanho3; n_sub = sub_ss; n_mux = mux_exp;
        end else if (mux_saida) begin
          r_renorms++; rn_t2 = tamanho2; rn_t3 = tamanho3; rn_sub = sub_ss;
        end else begin
          e_t3 = tamanho3; e_sub = sub_ss; e_mux = mux_exp;
        end
      end
      if (done) begin
        r_cycles = c; r_tam = tamanho; r_soma_s = soma_s; r_soma_b = soma_b;
        r_sub_big = sub_big; r_zero = zero; r_busy = busy;
        break;
      end
    end
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(done), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  c;
    bit  saw_done;
    reset = 1'b1; start = 1'b0; op_mul = 1'b0; op_sub = 1'b0;
    exp_diff = '0; big_ula_out = '0; overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("reset_outputs", 32'(all_outs), 0);
    check_val("reset_state", 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk); reset = 1'b0;

    // 1: add, leading one already at bit 25
    run_op(1'b0, 1'b0, 8'd3, 26'h2000000, 1'b0, 1'b0);
    check_val("t1_latency", r_cycles, 7);
    check_val("t1_loads", r_loads, 2);
    check_val("t1_tamanho", 32'(r_tam), 3);
    check_val("t1_norm_t2", 32'(n_t2), 0);
    check_val("t1_norm_t3", 32'(n_t3), 0);
    check_val("t1_loade_t3", 32'(e_t3), 3);
    check_val("t1_loade_sub", 32'(e_sub), 0);
    check_val("t1_loade_mux", 32'(e_mux), 0);
    check_val("t1_zero", 32'(r_zero), 0);
    check_val("t1_busy_at_done", 32'(r_busy), 0);
    check_val("t1_soma", 32'({r_soma_s, r_soma_b}), 3);

    // 2: subtract, leading one at bit 22 -> sh = 3
    run_op(1'b0, 1'b1, 8'd5, 26'h0400000, 1'b0, 1'b0);
    check_val("t2_latency", r_cycles, exp_lat(26'h0400000, 1'b0));
    check_val("t2_norm_seen", r_norms, 1);
    check_val("t2_norm_t2", 32'(n_t2), 3);
    check_val("t2_norm_t3", 32'(n_t3), 3);
    check_val("t2_norm_sub", 32'(n_sub), 1);
    check_val("t2_norm_mux", 32'(n_mux), 1);
    check_val("t2_sub_big", 32'(r_sub_big), 1);

    // 3: saturation of the align amount, boundary at 26, lowest-bit one, zero mantissa
    run_op(1'b0, 1'b0, 8'd40, 26'h2000000, 1'b0, 1'b0);
    check_val("t3_tamanho_sat", 32'(r_tam), 26);
    run_op(1'b0, 1'b0, 8'd26, 26'h0000001, 1'b0, 1'b0);
    check_val("t3_tamanho_26", 32'(r_tam), 26);
    check_val("t3_bit0_sh", 32'(n_t2), 25);
    check_val("t3_bit0_latency", r_cycles, exp_lat(26'h0000001, 1'b0));
    run_op(1'b0, 1'b0, 8'd7, 26'h0000000, 1'b0, 1'b0);
    check_val("t3_zero_flag", 32'(r_zero), 1);
    check_val("t3_zero_loads", r_loads, 0);
    check_val("t3_zero_latency", r_cycles, exp_lat(26'h0000000, 1'b0));

    // 4: overflow held -> exactly one renormalisation
    run_op(1'b0, 1'b0, 8'd2, 26'h1000000, 1'b1, 1'b0);
    check_val("t4_renorms", r_renorms, 1);
    check_val("t4_renorm_t2", 32'(rn_t2), 1);
    check_val("t4_renorm_t3", 32'(rn_t3), 1);
    check_val("t4_renorm_sub", 32'(rn_sub), 0);
    check_val("t4_loads", r_loads, 3);
    check_val("t4_norm_t2", 32'(n_t2), 1);
    check_val("t4_latency", r_cycles, exp_lat(26'h1000000, 1'b1));

    // 5a: start (with op_mul flipped) while busy is ignored
    run_op(1'b0, 1'b0, 8'd4, 26'h0800000, 1'b0, 1'b1);
    check_val("t5_poke_soma", 32'({r_soma_s, r_soma_b}), 3);
    check_val("t5_poke_latency", r_cycles, exp_lat(26'h0800000, 1'b0));
    check_val("t5_poke_loads", r_loads, 2);
    check_val("t5_poke_idle", 32'(busy), 0);

    // 5b: asynchronous reset during SCAN
    @(negedge clk);
    op_mul = 1'b0; op_sub = 1'b0; exp_diff = 8'd1; big_ula_out = '0; overflow = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (state_dbg != S_SCAN && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("t5_reach_scan", 32'(state_dbg), 32'(S_SCAN));
    #2 reset = 1'b1;
    #1 check_val("t5_reset_outputs", 32'(all_outs), 0);
    @(negedge clk); reset = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("t5_no_done_after_reset", 32'(saw_done), 0);

    // 6: multiply path
    run_op(1'b1, 1'b1, 8'd9, 26'h2000000, 1'b0, 1'b0);
    check_val("t6_soma", 32'({r_soma_s, r_soma_b}), 0);
    check_val("t6_tamanho", 32'(r_tam), 0);
    check_val("t6_sub_big", 32'(r_sub_big), 0);
    check_val("t6_loade_t3", 32'(e_t3), 0);
    check_val("t6_latency", r_cycles, 7);

    // 7: start held high through done starts a new operation
    @(negedge clk);
    op_mul = 1'b0; op_sub = 1'b0; exp_diff = 8'd1; big_ula_out = 26'h2000000; start = 1'b1;
    c = 0;
    while (!done && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("t7_first_done", 32'(done), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("t7_restart_busy", 32'(busy), 1);
    start = 1'b0;
    c = 0;
    while (!done && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    check_val("t7_second_done", 32'(done), 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
